// File: rtl/fft64_pkg.sv
// Shared definitions for the fft64 input controller: FSM encoding and default sizes.
package fft64_pkg;

  localparam int N_PTS_DEF = 64;
  localparam int SPW_DEF   = 4;
  localparam int DW_DEF    = 11;
  localparam int WORD_W    = 128;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAITD = 3'd2,
    S_FEED  = 3'd3,
    S_STALL = 3'd4,
    S_DRAIN = 3'd5
  } state_e;

endpackage

// File: rtl/fft64_unpack.sv
// Selects one complex sample from a 128-bit reader word; each 32-bit slot holds
// the real part in its low half and the imaginary part in its high half.
module fft64_unpack
  import fft64_pkg::*;
#(
  parameter int SPW = SPW_DEF,
  parameter int DW  = DW_DEF,
  parameter int IW  = (SPW > 1) ? $clog2(SPW) : 1
) (
  input  logic [WORD_W-1:0] word,
  input  logic [IW-1:0]     idx,
  output logic [DW-1:0]     re,
  output logic [DW-1:0]     im
);

  logic unused_word;

  // Only the low DW bits of each 16-bit half reach fft64; the rest are discarded.
  assign unused_word = ^word;

  always_comb begin
    re = '0;
    im = '0;
    for (int k = 0; k < SPW; k++) begin
      if (int'(idx) == k) begin
        re = word[32*k +: DW];
        im = word[32*k+16 +: DW];
      end
    end
  end

endmodule

// File: rtl/fft64_ctrl.sv
// Feeds one 64-point frame at a time from the sample FIFO into fft64, then waits
// for all result bins before fetching the next frame.
module fft64_ctrl
  import fft64_pkg::*;
#(
  parameter int N_PTS = N_PTS_DEF,
  parameter int SPW   = SPW_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                start,
  input  logic [7:0]          n_frames,
  input  logic                stop,
  input  logic [WORD_W-1:0]   reader_data,
  input  logic                reader_empty,
  output logic                reader_en,
  output logic                valid_a,
  output logic [DW-1:0]       ar,
  output logic [DW-1:0]       ai,
  input  logic                full,
  input  logic                valid_o,
  output logic                busy,
  output logic                frame_done,
  output logic [2:0]          state
);

  localparam int CW = $clog2(N_PTS);
  localparam int IW = (SPW > 1) ? $clog2(SPW) : 1;

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [CW-1:0]       samp_cnt_q, samp_cnt_d;
  logic [CW-1:0]       bin_cnt_q, bin_cnt_d;
  logic [7:0]          frame_cnt_q, frame_cnt_d;
  logic [7:0]          n_frames_q, n_frames_d;
  logic                stop_seen_q, stop_seen_d;

  logic [IW-1:0]       idx;
  logic [DW-1:0]       re, im;

  assign idx = samp_cnt_q[IW-1:0];

  fft64_unpack #(
    .SPW (SPW),
    .DW  (DW),
    .IW  (IW)
  ) u_unpack (
    .word (word_q),
    .idx  (idx),
    .re   (re),
    .im   (im)
  );

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    samp_cnt_d  = samp_cnt_q;
    bin_cnt_d   = bin_cnt_q;
    frame_cnt_d = frame_cnt_q;
    n_frames_d  = n_frames_q;
    stop_seen_d = stop_seen_q;
    reader_en   = 1'b0;
    valid_a     = 1'b0;
    frame_done  = 1'b0;

    if (state_q != S_IDLE && stop) begin
      stop_seen_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_FETCH;
          n_frames_d  = n_frames;
          samp_cnt_d  = '0;
          bin_cnt_d   = '0;
          frame_cnt_d = '0;
        end
      end
      S_FETCH: begin
        if (!reader_empty) begin
          reader_en = 1'b1;
          state_d   = S_WAITD;
        end
      end
      S_WAITD: begin
        word_d  = reader_data;
        state_d = S_FEED;
      end
      // A stalled sample goes out on the first cycle full drops, so STALL accepts like FEED.
      S_FEED, S_STALL: begin
        if (full) begin
          state_d = S_STALL;
        end else begin
          valid_a    = 1'b1;
          samp_cnt_d = samp_cnt_q + 1'b1;
          if (samp_cnt_q == CW'(N_PTS - 1)) begin
            state_d    = S_DRAIN;
            samp_cnt_d = '0;
          end else if (idx == IW'(SPW - 1)) begin
            state_d = S_FETCH;
          end else begin
            state_d = S_FEED;
          end
        end
      end
      S_DRAIN: begin
        if (valid_o) begin
          bin_cnt_d = bin_cnt_q + 1'b1;
          if (bin_cnt_q == CW'(N_PTS - 1)) begin
            frame_done  = 1'b1;
            bin_cnt_d   = '0;
            frame_cnt_d = frame_cnt_q + 8'd1;
            if (stop_seen_q || stop || (n_frames_q != 8'd0 && frame_cnt_d == n_frames_q)) begin
              state_d = S_IDLE;
            end else begin
              state_d = S_FETCH;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_IDLE) begin
      stop_seen_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= S_IDLE;
      word_q      <= '0;
      samp_cnt_q  <= '0;
      bin_cnt_q   <= '0;
      frame_cnt_q <= '0;
      n_frames_q  <= '0;
      stop_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      samp_cnt_q  <= samp_cnt_d;
      bin_cnt_q   <= bin_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      n_frames_q  <= n_frames_d;
      stop_seen_q <= stop_seen_d;
    end
  end

  assign ar    = valid_a ? re : '0;
  assign ai    = valid_a ? im : '0;
  assign busy  = (state_q != S_IDLE);
  assign state = state_q;

endmodule

// File: tb/tb_fft64_ctrl.sv
// Directed bench for fft64_ctrl: models the sample FIFO and fft64 result strobes,
// and checks every presented sample against hand-built word contents.
module tb_fft64_ctrl;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         start = 1'b0;
  logic [7:0]   n_frames = 8'd0;
  logic         stop = 1'b0;
  logic [127:0] reader_data = '0;
  logic         reader_empty = 1'b0;
  logic         reader_en;
  logic         valid_a;
  logic [10:0]  ar, ai;
  logic         full = 1'b0;
  logic         valid_o = 1'b0;
  logic         busy;
  logic         frame_done;
  logic [2:0]   state;

  int nChecks = 0;
  int nFails  = 0;
  int cyc = 0;
  int accCnt = 0, reCnt = 0, fdCnt = 0, drainPulses = 0, binsGiven = 0;
  int firstEnCyc = -1;
  int accCyc[256];
  int rdPtr = 0;
  bit popPending = 0;
  bit noise = 0;
  bit specialMode = 0;

  fft64_ctrl dut (
    .CLK          (CLK),
    .RST          (RST),
    .start        (start),
    .n_frames     (n_frames),
    .stop         (stop),
    .reader_data  (reader_data),
    .reader_empty (reader_empty),
    .reader_en    (reader_en),
    .valid_a      (valid_a),
    .ar           (ar),
    .ai           (ai),
    .full         (full),
    .valid_o      (valid_o),
    .busy         (busy),
    .frame_done   (frame_done),
    .state        (state)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] sampRe(input int j);
    return 11'(j * 37 + 5);
  endfunction

  function automatic logic [10:0] sampIm(input int j);
    return 11'(j * 91 + 700);
  endfunction

  // Upper bits of each 16-bit half carry junk that must never reach ar/ai.
  function automatic logic [127:0] mkWord(input int w);
    logic [127:0] v = '0;
    if (specialMode) begin
      if (w == 0) v[10:0] = 11'h3FF;
    end else begin
      for (int k = 0; k < 4; k++) begin
        v[32*k +: 16]    = {5'b10110, sampRe(4*w + k)};
        v[32*k+16 +: 16] = {5'b01101, sampIm(4*w + k)};
      end
    end
    return v;
  endfunction

  function automatic logic [10:0] expRe(input int j);
    if (specialMode) return (j == 0) ? 11'h3FF : 11'h000;
    return sampRe(j);
  endfunction

  function automatic logic [10:0] expIm(input int j);
    if (specialMode) return 11'h000;
    return sampIm(j);
  endfunction

  always @(posedge CLK) cyc++;

  // FIFO and fft64 model: data follows a pop by one cycle; bins stream once DRAIN is seen.
  always @(posedge CLK) begin
    #1;
    if (popPending) begin
      reader_data = mkWord(rdPtr);
      rdPtr++;
      popPending = 0;
    end else begin
      reader_data = {4{32'hA5A5_5A5A}};
    end
    if (state == 3'd5 && binsGiven < 64) begin
      valid_o = 1'b1;
      binsGiven++;
    end else begin
      valid_o = noise && (state == 3'd3);
      if (state != 3'd5) binsGiven = 0;
    end
  end

  always @(negedge CLK) begin
    if (reader_en) begin
      reCnt++;
      popPending = 1;
      if (firstEnCyc < 0) firstEnCyc = cyc;
    end
    if (valid_a) begin
      if (accCnt < 256) accCyc[accCnt] = cyc;
      checkOutput("sampleRe", 32'(ar), 32'(expRe(accCnt)));
      checkOutput("sampleIm", 32'(ai), 32'(expIm(accCnt)));
      accCnt++;
    end else begin
      checkOutput("zeroWhenIdle", 32'({ar, ai}), 32'd0);
    end
    if (state == 3'd5) begin
      checkOutput("noValidInDrain", 32'(valid_a), 32'd0);
      if (valid_o) drainPulses++;
    end
    if (frame_done) begin
      fdCnt++;
      checkOutput("binsAtDone", drainPulses, 64);
      drainPulses = 0;
    end
  end

  task automatic clearCounters();
    accCnt = 0; reCnt = 0; fdCnt = 0; drainPulses = 0;
    firstEnCyc = -1; rdPtr = 0; popPending = 0;
  endtask

  task automatic applyStimulus(input logic [7:0] nFr);
    clearCounters();
    @(posedge CLK); #1;
    n_frames = nFr;
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    n_frames = 8'd0;
    checkOutput("busyAfterStart", 32'(busy), 32'd1);
  endtask

  task automatic waitIdle(input string tag, input int maxCycles);
    bit done = 0;
    for (int i = 0; i < maxCycles && !done; i++) begin
      @(posedge CLK); #1;
      if (state == 3'd0) done = 1;
    end
    checkOutput(tag, 32'(done), 32'd1);
    repeat (6) @(posedge CLK);
    #1;
    checkOutput({tag, "State"}, 32'(state), 32'd0);
    checkOutput({tag, "Busy"}, 32'(busy), 32'd0);
  endtask

  task automatic waitSample(input string tag, input int target, input logic [2:0] st, input int maxCycles);
    bit done = 0;
    for (int i = 0; i < maxCycles && !done; i++) begin
      @(posedge CLK); #1;
      if (accCnt >= target && state == st) done = 1;
    end
    checkOutput(tag, 32'(done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL globalTimeout: got running, expected finished");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    #1 RST = 1'b0;
    #1;
    checkOutput("rstState", 32'(state), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstOutputs", 32'({reader_en, valid_a, frame_done, ar, ai}), 32'd0);
    repeat (3) @(posedge CLK);
    #3 RST = 1'b1;

    $display("[TB] single frame, FIFO always ready");
    noise = 1;
    applyStimulus(8'd1);
    waitIdle("oneFrameIdle", 2000);
    noise = 0;
    checkOutput("oneFramePops", reCnt, 16);
    checkOutput("oneFrameSamples", accCnt, 64);
    checkOutput("oneFrameDone", fdCnt, 1);
    checkOutput("popToValidLatency", accCyc[0] - firstEnCyc, 2);

    $display("[TB] sparse word, only first real sample nonzero");
    specialMode = 1;
    applyStimulus(8'd1);
    waitIdle("sparseIdle", 2000);
    checkOutput("sparseSamples", accCnt, 64);
    checkOutput("sparseDone", fdCnt, 1);
    specialMode = 0;

    $display("[TB] backpressure at sample 10");
    applyStimulus(8'd1);
    waitSample("reachSample10", 10, 3'd3, 500);
    full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      checkOutput("stallNoValid", 32'(valid_a), 32'd0);
      @(posedge CLK); #1;
    end
    full = 1'b0;
    waitIdle("stallIdle", 2000);
    checkOutput("stallSamples", accCnt, 64);
    checkOutput("stallGap", accCyc[10] - accCyc[9], 6);
    checkOutput("stallDone", fdCnt, 1);

    $display("[TB] FIFO empty before word 3");
    applyStimulus(8'd1);
    begin
      bit seen = 0;
      for (int i = 0; i < 500 && !seen; i++) begin
        @(posedge CLK); #1;
        if (reCnt == 3 && state == 3'd1) seen = 1;
      end
      checkOutput("reachWord3", 32'(seen), 32'd1);
    end
    reader_empty = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      checkOutput("emptyNoPop", 32'(reader_en), 32'd0);
      checkOutput("emptyNoValid", 32'(valid_a), 32'd0);
      checkOutput("emptyHoldFetch", 32'(state), 32'd1);
      @(posedge CLK); #1;
    end
    reader_empty = 1'b0;
    waitIdle("emptyIdle", 2000);
    checkOutput("emptyPops", reCnt, 16);
    checkOutput("emptySamples", accCnt, 64);
    checkOutput("emptyDone", fdCnt, 1);

    $display("[TB] continuous run with stop in frame 2");
    applyStimulus(8'd0);
    waitSample("reachStopPoint", 94, 3'd3, 1000);
    stop = 1'b1;
    @(posedge CLK); #1;
    stop = 1'b0;
    waitIdle("stopIdle", 2000);
    checkOutput("stopSamples", accCnt, 128);
    checkOutput("stopDones", fdCnt, 2);

    $display("[TB] reset during FEED");
    applyStimulus(8'd1);
    waitSample("reachMidFeed", 20, 3'd3, 500);
    #2;
    checkOutput("preResetValid", 32'(valid_a), 32'd1);
    RST = 1'b0;
    #1;
    checkOutput("asyncRstState", 32'(state), 32'd0);
    checkOutput("asyncRstBusy", 32'(busy), 32'd0);
    checkOutput("asyncRstOutputs", 32'({reader_en, valid_a, frame_done, ar, ai}), 32'd0);
    clearCounters();
    repeat (2) @(posedge CLK);
    #3 RST = 1'b1;
    repeat (10) @(posedge CLK);
    #1;
    checkOutput("postResetIdle", 32'(state), 32'd0);
    checkOutput("postResetNoPop", reCnt, 0);
    applyStimulus(8'd1);
    waitIdle("cleanFrameIdle", 2000);
    checkOutput("cleanFrameSamples", accCnt, 64);
    checkOutput("cleanFrameDone", fdCnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/fft64_ctrl.md
FFT64_CTRL -- requirements
Module: fft64_ctrl

Interface
REQ-001 SHALL have parameter N_PTS, default 64, meaning samples per FFT frame.
REQ-002 SHALL have parameter SPW, default 4, meaning complex samples per 128-bit reader word.
REQ-003 SHALL have parameter DW, default 11, meaning signed sample width fed to fft64.
REQ-004 SHALL have port CLK input 1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port RST input 1: asynchronous, active-low reset.
REQ-006 SHALL have port start input 1: a one-cycle pulse that begins a run in IDLE; ignored elsewhere.
REQ-007 SHALL have port n_frames input 8: frames per run, latched at start; 0 means continuous until stop.
REQ-008 SHALL have port stop input 1: a pulse requesting end of run after the current frame.
REQ-009 SHALL have port reader_data input 128: word from the sample FIFO, valid the cycle after reader_en.
REQ-010 SHALL have port reader_empty input 1: FIFO empty flag.
REQ-011 SHALL have port reader_en output 1: FIFO pop strobe.
REQ-012 SHALL have port valid_a output 1: sample strobe to fft64.
REQ-013 SHALL have ports ar and ai, each output DW: signed real and imaginary sample to fft64.
REQ-014 SHALL have port full input 1: fft64 input backpressure.
REQ-015 SHALL have port valid_o input 1: fft64 output strobe; one per result bin.
REQ-016 SHALL have port busy output 1: high in every state except IDLE.
REQ-017 SHALL have port frame_done output 1: a one-cycle pulse when the last output bin of a frame is counted.
REQ-018 SHALL have port state output 3: current FSM encoding, for debug.

Function
REQ-019 SHALL implement the FSM states IDLE=0, FETCH=1, WAITD=2, FEED=3, STALL=4, DRAIN=5.
REQ-020 SHALL make the IDLE->FETCH transition on start, latching n_frames and clearing all counters.
REQ-021 SHALL, in FETCH, assert reader_en for exactly one cycle when reader_empty=0 and go to WAITD; with reader_empty=1 it SHALL hold in FETCH with reader_en=0.
REQ-022 SHALL, in WAITD, capture reader_data into a 128-bit word register and go to FEED.
REQ-023 SHALL unpack sample k (0..SPW-1) as bits [32k+15:32k] for real and [32k+31:32k+16] for imaginary, keeping the low DW bits unchanged, with k=0 first.
REQ-024 SHALL, in FEED, assert valid_a with the current sample only while full=0; with full=1 it SHALL go to STALL with valid_a=0 and the sample index held.
REQ-025 SHALL return STALL->FEED on the first cycle full=0, presenting the same sample.
REQ-026 SHALL increment the 6-bit in-frame sample counter per accepted sample; after sample SPW-1 of a word it SHALL go to FETCH, and after sample N_PTS-1 to DRAIN.
REQ-027 SHALL keep ar and ai at 0 whenever valid_a=0.
REQ-028 SHALL, in DRAIN, count valid_o pulses; on the N_PTS-th pulse it SHALL pulse frame_done and increment the frame counter.
REQ-029 SHALL, after frame_done, go to IDLE if stop has been seen or frame count equals a nonzero n_frames, otherwise to FETCH.
REQ-030 SHALL record a stop pulse in any non-IDLE state in a sticky flag cleared on entering IDLE; it SHALL never truncate a frame.
REQ-031 SHALL ignore valid_o outside DRAIN.
REQ-032 SHALL keep one frame in flight at most: no valid_a from the first DRAIN cycle until frame_done.
REQ-033 SHALL give the latency from reader_en to the first valid_a of that word as 2 cycles when full=0.

Reset
REQ-034 SHALL, while RST=0, force state=IDLE, reader_en=0, valid_a=0, ar=0, ai=0, busy=0, frame_done=0, all counters, the stop flag and the word register to 0, regardless of CLK.
REQ-035 SHALL, on reset mid-frame, abandon the frame; after release it SHALL wait in IDLE for start.

Structure
REQ-036 SHALL place the state encoding, N_PTS, SPW and DW defaults in shared package fft64_pkg.
REQ-037 SHALL place the word-to-sample unpacking in one sub-module, fft64_unpack: a combinational mux of word and index to ar/ai.

Verification
REQ-038 SHALL cover: start, n_frames=1, FIFO never empty, full=0, 64 valid_o after DRAIN -> 16 reader_en pulses, 64 valid_a, one frame_done, then IDLE with busy=0.
REQ-039 SHALL cover: word 0 with bits [10:0]=0x3FF and all else 0 -> first sample ar=1023, ai=0, remaining samples 0.
REQ-040 SHALL cover: full=1 for 5 cycles at sample 10 -> valid_a low for 5 cycles, sample 10 presented once after release, 64 total samples.
REQ-041 SHALL cover: reader_empty=1 for 8 cycles at word 3 -> FETCH held, reader_en=0, no valid_a, frame completes normally.
REQ-042 SHALL cover: n_frames=0 with stop at sample 30 of frame 2 -> frame 2 completes, frame_done twice, then IDLE.
REQ-043 SHALL cover: RST=0 mid-FEED -> all outputs 0 asynchronously; start after release -> a clean frame from sample 0.
